serial_sub_32: RTL and testbench

SERIAL_SUB_32 -- requirements
Module: serial_sub_32

---
 rtl/serial_sub_32.sv | 133 +++++++++++++
 tb/tb_serial_sub_32.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub_32.sv
// Multi-cycle 32-bit subtractor: CHUNK bits per clock, LSB slice first,
// borrow carried between slices in a flip-flop.
module serial_sub_32 #(
    parameter int CHUNK = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        b_in,
    output logic [31:0] diff,
    output logic        b_out,
    output logic        busy,
    output logic        done
);

    localparam int N  = 32 / CHUNK;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [31:0]     r_a;
    logic [31:0]     r_b;
    logic [31:0]     r_res;
    logic [31:0]     r_diff;
    logic            r_bout;
    logic            r_borrow;
    logic [CW-1:0]   r_cnt;

    logic            w_accept;
    logic            w_run;
    logic            w_last;
    logic            w_bw;
    logic [CHUNK-1:0] w_d;
    logic [31:0]     w_res;

    // Ripple-borrow chain over the current low slice of the operands.
    always_comb begin
        w_d  = '0;
        w_bw = r_borrow;
        for (int i = 0; i < CHUNK; i++) begin
            w_d[i] = r_a[i] ^ r_b[i] ^ w_bw;
            w_bw   = (~r_a[i] & r_b[i]) | (~(r_a[i] ^ r_b[i]) & w_bw);
        end
    end

    assign w_res = {w_d, r_res[31:CHUNK]};
    assign w_last = (r_cnt == CW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_run    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                busy  = 1'b1;
                w_run = 1'b1;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_a      <= a;
            r_b      <= b;
            r_res    <= '0;
            r_borrow <= b_in;
            r_cnt    <= '0;
        end else if (w_run) begin
            // Operands shift down so the next slice is always at bit 0.
            r_a      <= r_a >> CHUNK;
            r_b      <= r_b >> CHUNK;
            r_res    <= w_res;
            r_borrow <= w_bw;
            r_cnt    <= r_cnt + CW'(1);
            if (w_last) begin
                r_diff <= w_res;
                r_bout <= w_bw;
            end
        end
    end

    assign diff  = r_diff;
    assign b_out = r_bout;

endmodule

// File: tb/tb_serial_sub_32.sv
// Bench for serial_sub_32: one instance per legal CHUNK, directed table,
// multi-cycle corner sequences and a queue scoreboard over random operands.
module tb_serial_sub_32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start [4];
    logic [31:0] a     [4];
    logic [31:0] b     [4];
    logic        bin   [4];
    logic [31:0] diff  [4];
    logic        bout  [4];
    logic        busy  [4];
    logic        done  [4];

    int n_pass  = 0;
    int n_total = 0;

    logic [32:0] sb [4][$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        bin;
        logic [31:0] d;
        logic        bo;
    } vec_t;

    vec_t tbl [7];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        serial_sub_32 #(.CHUNK(1 << g)) u_dut (
            .clk   (clk),
            .reset (reset),
            .start (start[g]),
            .a     (a[g]),
            .b     (b[g]),
            .b_in  (bin[g]),
            .diff  (diff[g]),
            .b_out (bout[g]),
            .busy  (busy[g]),
            .done  (done[g])
        );
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [32:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic        bi);
        return {1'b0, x} - {1'b0, y} - {32'd0, bi};
    endfunction

    // Scoreboard: every done pulse pops the oldest expected result.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (done[k] === 1'b1) begin
                if (sb[k].size() == 0) begin
                    chk($sformatf("done_without_start_%0d", k), 64'd1, 64'd0);
                end else begin
                    chk($sformatf("sb_result_c%0d", 1 << k),
                        64'({bout[k], diff[k]}), 64'(sb[k].pop_front()));
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the DONE cycle.
    task automatic run_op(input int k, input logic [31:0] va,
                          input logic [31:0] vb, input logic vbi,
                          input logic [32:0] exp);
        int nn;
        int cyc;
        int bcnt;
        nn   = 32 >> k;
        cyc  = 0;
        bcnt = 0;
        start[k] = 1'b1;
        a[k]     = va;
        b[k]     = vb;
        bin[k]   = vbi;
        sb[k].push_back(exp);
        @(posedge clk); #1;
        start[k] = 1'b0;
        a[k]     = $urandom;
        b[k]     = $urandom;
        bin[k]   = 1'($urandom_range(0, 1));
        if (busy[k] === 1'b1) bcnt++;
        while (done[k] !== 1'b1 && cyc < nn + 4) begin
            @(posedge clk); #1;
            cyc++;
            if (busy[k] === 1'b1) bcnt++;
        end
        chk($sformatf("latency_c%0d", 1 << k), 64'(cyc), 64'(nn));
        chk($sformatf("busy_cycles_c%0d", 1 << k), 64'(bcnt), 64'(nn));
    endtask

    task automatic idle_tail(input int k);
        @(posedge clk); #1;
        chk($sformatf("tail_c%0d", 1 << k), 64'({busy[k], done[k]}), 64'd0);
    endtask

    initial begin
        int k;
        int ph;
        bit bad;
        logic [31:0] va;
        logic [31:0] vb;
        logic        vbi;

        tbl[0] = '{32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 1'b0};
        tbl[1] = '{32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b1};
        tbl[2] = '{32'hAFAFAAFF, 32'hAEBAEBFF, 1'b1, 32'h00F4BEFF, 1'b0};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[4] = '{32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1'b1};
        tbl[5] = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 32'h00000000, 1'b0};
        tbl[6] = '{32'h12345678, 32'h00000000, 1'b0, 32'h12345678, 1'b0};

        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            start[i] = 1'b0;
            a[i]     = '0;
            b[i]     = '0;
            bin[i]   = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("reset_state_c%0d", 1 << i),
                64'({busy[i], done[i], bout[i], diff[i]}), 64'd0);
        end
        reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 4; j++) begin
                run_op(j, tbl[i].a, tbl[i].b, tbl[i].bin,
                       {tbl[i].bo, tbl[i].d});
                chk($sformatf("tbl%0d_c%0d", i, 1 << j),
                    64'({bout[j], diff[j]}), 64'({tbl[i].bo, tbl[i].d}));
                idle_tail(j);
            end
        end

        // start held high, operands scrambled during RUN, back-to-back relaunch
        k = 2;
        ph = 0;
        start[k] = 1'b1;
        a[k]     = 32'h13572468;
        b[k]     = 32'h24681357;
        bin[k]   = 1'b1;
        sb[k].push_back(model(32'h13572468, 32'h24681357, 1'b1));
        for (int c = 0; c < 40 && ph != 3; c++) begin
            @(posedge clk); #1;
            if (ph == 0 && done[k] === 1'b1) begin
                ph  = 1;
                va  = $urandom;
                vb  = $urandom;
                a[k]   = va;
                b[k]   = vb;
                bin[k] = 1'b1;
                sb[k].push_back(model(va, vb, 1'b1));
            end else if (ph == 1) begin
                chk("b2b_no_idle", 64'(busy[k]), 64'd1);
                start[k] = 1'b0;
                ph = 2;
            end else if (ph == 2 && done[k] === 1'b1) begin
                ph = 3;
            end else if (ph == 0) begin
                a[k]   = $urandom;
                b[k]   = $urandom;
                bin[k] = 1'($urandom_range(0, 1));
            end
        end
        chk("b2b_second_done", 64'(ph), 64'd3);
        idle_tail(k);

        // reset with start=1 on the third RUN cycle aborts the operation
        run_op(k, 32'h00000009, 32'h00000002, 1'b0, 33'h000000007);
        idle_tail(k);
        start[k] = 1'b1;
        a[k]     = 32'hDEADBEEF;
        b[k]     = 32'h01234567;
        bin[k]   = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset    = 1'b1;
        start[k] = 1'b1;
        @(posedge clk); #1;
        chk("abort_state", 64'({busy[k], done[k], bout[k], diff[k]}), 64'd0);
        reset    = 1'b0;
        start[k] = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (done[k] !== 1'b0 || diff[k] !== 32'd0) bad = 1'b1;
        end
        chk("abort_no_done", 64'(bad), 64'd0);

        for (int j = 0; j < 4; j++) begin
            for (int i = 0; i < 1000; i++) begin
                va  = $urandom;
                vb  = (i % 8 == 0) ? va : $urandom;
                vbi = 1'($urandom_range(0, 1));
                run_op(j, va, vb, vbi, model(va, vb, vbi));
            end
            idle_tail(j);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb[0].size() + sb[1].size() + sb[2].size()
                            + sb[3].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
